// File: rtl/axis_fifo_pkg.sv
// Shared types and width helpers for the AXI-Stream FIFO.
// The optional store-and-forward mode is enabled with AXIS_FIFO_STORE_FWD_EN.
package axis_fifo_pkg;

  function automatic int keep_width_of(input int data_width);
    return data_width / 8;
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_KEEP_WIDTH = keep_width_of(DEF_DATA_WIDTH);
  localparam int DEF_BEAT_WIDTH = DEF_DATA_WIDTH + DEF_KEEP_WIDTH + 1;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] tdata;
    logic [DEF_KEEP_WIDTH-1:0] tkeep;
    logic                      tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port beat storage: synchronous write, registered read address.
// Store-and-forward (AXIS_FIFO_STORE_FWD_EN) does not affect this block.
module axis_fifo_mem
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_BEAT_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2_cnt(DEPTH) - 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/axis_fifo_ch.sv
// AXI-Stream FIFO with occupancy/packet counters and first-word fall-through.
// Define AXIS_FIFO_STORE_FWD_EN to hold output until a whole packet is stored.
module axis_fifo_ch
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 16,
  localparam int KEEP_WIDTH = keep_width_of(DATA_WIDTH),
  localparam int CNT_WIDTH  = clog2_cnt(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  overflow_err
);

  localparam int AW = CNT_WIDTH - 1;
  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1;

  // Handshake: a beat moves on a side only in a cycle where valid and ready
  // are both high at the rising edge; valid never waits on ready.
  logic [CNT_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_WIDTH-1:0] pkt_after_rd;
  logic [BW-1:0]        head;
  logic                 full, wr, rd, head_last, avail, gate, tvalid_q;

  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occupancy = wr_ptr - rd_ptr;

  assign s_axis_tready = !full && !areset;
  assign m_axis_tvalid = tvalid_q;
  assign wr = s_axis_tvalid && s_axis_tready;
  assign rd = tvalid_q && m_axis_tready;

  assign head_last = head[0];
  assign pkt_after_rd = pkt_count - CNT_WIDTH'(rd && head_last);
  // Entries left after this edge's read that were already stored before it.
  assign avail = (occupancy - CNT_WIDTH'(rd)) != '0;

  always_comb begin
    wr_ptr_nxt = wr_ptr + CNT_WIDTH'(wr);
    rd_ptr_nxt = rd_ptr + CNT_WIDTH'(rd);
    if (areset) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end
  end

  axis_fifo_mem #(.WIDTH(BW), .DEPTH(DEPTH)) u_mem (
    .clk     (aclk),
    .wr_en   (wr),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .rd_addr (rd_ptr_nxt[AW-1:0]),
    .rd_data (head)
  );

`ifdef AXIS_FIFO_STORE_FWD_EN
  logic in_pkt, in_pkt_nxt, ovf_q;

  assign in_pkt_nxt = rd ? !head_last : in_pkt;
  // Releasing at full keeps packets longer than the FIFO from deadlocking.
  assign gate = (pkt_after_rd != '0) || in_pkt_nxt || full;
  assign overflow_err = ovf_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      in_pkt <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      in_pkt <= in_pkt_nxt;
      if (s_axis_tvalid && full && pkt_count == '0) ovf_q <= 1'b1;
    end
  end
`else
  assign gate = 1'b1;
  assign overflow_err = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      tvalid_q  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      pkt_count <= pkt_after_rd + CNT_WIDTH'(wr && s_axis_tlast);
      tvalid_q  <= avail && gate;
    end
  end

  // Outputs read as zero whenever no beat is presented.
  assign m_axis_tdata = tvalid_q ? head[BW-1 -: DATA_WIDTH] : '0;
  assign m_axis_tkeep = tvalid_q ? head[KEEP_WIDTH:1] : '0;
  assign m_axis_tlast = tvalid_q && head_last;

endmodule

// File: tb/tb_axis_fifo_ch.sv
// Self-checking bench for axis_fifo_ch against a queue-based reference model.
// Store-and-forward checks are built when AXIS_FIFO_STORE_FWD_EN is defined.
module tb_axis_fifo_ch;
  import axis_fifo_pkg::*;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int BW    = DW + KW + 1;

  logic          aclk;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] pkt_count;
  logic          overflow_err;

  axis_fifo_ch #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count),
    .overflow_err  (overflow_err)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Scoreboard: stored beats in order, plus the edge index each was written at.
  logic [BW-1:0] exp_q[$];
  int            wcyc_q[$];
  int            cyc = 0;
  logic          m_in_pkt = 1'b0;
  logic          m_full_pre = 1'b0;
  logic          m_ovf = 1'b0;
  logic          rst_prev = 1'b0;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A beat becomes visible one edge after the edge that wrote it.
  function automatic logic model_valid();
    logic any_vis = 1'b0;
    logic last_vis = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (wcyc_q[i] < cyc) begin
        any_vis = 1'b1;
        if (exp_q[i][0]) last_vis = 1'b1;
      end
    end
`ifdef AXIS_FIFO_STORE_FWD_EN
    return any_vis && (last_vis || m_in_pkt || m_full_pre);
`else
    return any_vis && (last_vis || !last_vis);
`endif
  endfunction

  function automatic int count_last();
    int n = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i][0]) n++;
    return n;
  endfunction

  task automatic tick();
    logic          e_rdy, e_vld, sv, mr, rst, full_now;
    logic [BW-1:0] beat, popped;
    @(negedge aclk);
    e_rdy = !areset && (exp_q.size() < DEPTH);
    e_vld = model_valid();
    chk("s_tready", 128'(s_axis_tready), 128'(e_rdy));
    chk("m_tvalid", 128'(m_axis_tvalid), 128'(e_vld));
    chk("occupancy", 128'(occupancy), 128'(exp_q.size()));
    chk("pkt_count", 128'(pkt_count), 128'(count_last()));
    chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
    if (e_vld) chk("m_beat", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(exp_q[0]));
    if (rst_prev) chk("reset_out_zero", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(0));
    sv = s_axis_tvalid; mr = m_axis_tready; rst = areset;
    beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    @(posedge aclk);
    cyc++;
    rst_prev = rst;
    if (rst) begin
      exp_q.delete(); wcyc_q.delete();
      m_in_pkt = 1'b0; m_full_pre = 1'b0; m_ovf = 1'b0;
    end else begin
      full_now = (exp_q.size() == DEPTH);
`ifdef AXIS_FIFO_STORE_FWD_EN
      if (full_now && sv && count_last() == 0) m_ovf = 1'b1;
`endif
      if (e_vld && mr) begin
        popped = exp_q.pop_front();
        void'(wcyc_q.pop_front());
        m_in_pkt = !popped[0];
      end
      if (sv && e_rdy) begin
        exp_q.push_back(beat);
        wcyc_q.push_back(cyc);
      end
      m_full_pre = full_now;
    end
    #1;
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic mr);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    m_axis_tready = mr;
    tick();
  endtask

  task automatic drive_rand(input logic v, input logic l, input logic mr);
    drive(v, {$urandom, $urandom}, KW'($urandom), l, mr);
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    do_reset(3);

    // Single beat
    drive(1'b1, 64'hDEADBEEF_00000001, 8'hFF, 1'b1, 1'b0);
    chk("single_occ", 128'(occupancy), 128'(1));
    chk("single_pkt", 128'(pkt_count), 128'(1));
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("single_drained_occ", 128'(occupancy), 128'(0));
    chk("single_drained_pkt", 128'(pkt_count), 128'(0));

    // Fill against backpressure, then offer more beats that must be refused
    for (int i = 0; i < 20; i++) drive_rand(1'b1, 1'(i % 5 == 4), 1'b0);
    chk("fill_occ", 128'(occupancy), 128'(DEPTH));
    chk("fill_tready", 128'(s_axis_tready), 128'(0));
    for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Concurrent streaming at occupancy 3
    for (int i = 0; i < 3; i++) drive_rand(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive_rand(1'b1, 1'($urandom_range(0, 3) == 0), 1'b1);
      chk("stream_occ", 128'(occupancy), 128'(3));
    end
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Output stall stability with ready toggling
    for (int i = 0; i < 40; i++) drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'(i % 2));
    for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset mid-packet, then a clean packet
    for (int i = 0; i < 5; i++) drive_rand(1'b1, 1'b0, 1'b0);
    do_reset(1);
    chk("rst_mid_occ", 128'(occupancy), 128'(0));
    chk("rst_mid_valid", 128'(m_axis_tvalid), 128'(0));
    for (int i = 0; i < 3; i++) drive_rand(1'b1, 1'(i == 2), 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 24; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);

`ifdef AXIS_FIFO_STORE_FWD_EN
    // 4-beat packet is held back until its last beat is stored
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1, 1'(i == 3), 1'b1);
      chk("sf_hold_valid", 128'(m_axis_tvalid), 128'(0));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("sf_release_valid", 128'(m_axis_tvalid), 128'(1));
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);
    // 20-beat packet forces release at full
    for (int i = 0; i < 40 && exp_q.size() + 0 < 100; i++) drive_rand(1'(i < 20), 1'(i == 19), 1'b1);
    chk("sf_overflow", 128'(overflow_err), 128'(1));
    do_reset(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
